// File: rtl/keypad_event_fifo_if.sv
// CPU-side bundle for the keypad event FIFO: scan input, read strobe and queue status.
// The bench/system drives through master; the FIFO block connects through slave.
interface keypad_event_fifo_if #(
  parameter int unsigned DEPTH = 4
);
  logic                       tick;
  logic [3:0]                 key_value;
  logic                       rd_en;
  logic                       clr_ovf;
  logic [3:0]                 rd_data;
  logic                       empty;
  logic                       full;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       key_event;
  logic                       overflow;

  modport master (
    output tick, key_value, rd_en, clr_ovf,
    input  rd_data, empty, full, count, key_event, overflow
  );

  modport slave (
    input  tick, key_value, rd_en, clr_ovf,
    output rd_data, empty, full, count, key_event, overflow
  );
endinterface

// File: rtl/keypad_event_fifo.sv
// Debounces the held keypad code on the scan tick, emits one event per accepted press,
// and queues the key codes in a first-word-fall-through FIFO drained by CPU port reads.
module keypad_event_fifo #(
  parameter logic [3:0]  IDLE_CODE    = 4'hF,
  parameter int unsigned STABLE_TICKS = 3,
  parameter int unsigned DEPTH        = 4
) (
  input logic               clk,
  input logic               rst,
  keypad_event_fifo_if.slave bus
);
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam logic [3:0]  ST      = 4'(STABLE_TICKS);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  typedef enum logic [1:0] {RELEASED, CANDIDATE, PRESSED} keyState_e;

  keyState_e   state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic [3:0]  cand, candNext;
  logic        pushReq;
  logic        isIdle, candMatch, cntHit;

  logic [3:0]  mem [DEPTH];
  logic [PW:0] wrPtr, rdPtr;
  logic        doPush, doPop;
  logic        keyEvent, overflowQ;

  assign isIdle    = (bus.key_value == IDLE_CODE);
  assign candMatch = (bus.key_value == cand);
  assign cntHit    = ((cnt + 4'd1) == ST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      cand  <= candNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (bus.tick) begin
      unique case (state)
        RELEASED:  if (!isIdle) stateNext = CANDIDATE;
        CANDIDATE: if (!candMatch) stateNext = RELEASED;
                   else if (cntHit) stateNext = PRESSED;
        PRESSED:   if (isIdle && cntHit) stateNext = RELEASED;
        default:   stateNext = RELEASED;
      endcase
    end
  end

  always_comb begin
    cntNext  = cnt;
    candNext = cand;
    pushReq  = 1'b0;
    if (bus.tick) begin
      unique case (state)
        RELEASED: if (!isIdle) begin
          candNext = bus.key_value;
          cntNext  = 4'd1;
        end
        CANDIDATE: begin
          if (!candMatch)  cntNext = '0;
          else if (cntHit) begin
            cntNext = '0;
            pushReq = 1'b1;
          end else         cntNext = cnt + 4'd1;
        end
        PRESSED: begin
          // Any non-idle code (held or rolled-over key) restarts the release count.
          if (!isIdle || cntHit) cntNext = '0;
          else                   cntNext = cnt + 4'd1;
        end
        default: cntNext = '0;
      endcase
    end
  end

  assign bus.empty = (wrPtr == rdPtr);
  assign bus.full  = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
  assign bus.count = wrPtr - rdPtr;
  assign bus.rd_data   = mem[rdPtr[PW-1:0]];
  assign bus.key_event = keyEvent;
  assign bus.overflow  = overflowQ;

  // A pop on the same edge frees the slot, so a full FIFO can still accept the push.
  assign doPop  = bus.rd_en && !bus.empty;
  assign doPush = pushReq && (!bus.full || doPop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      mem       <= '{default: '0};
      keyEvent  <= 1'b0;
      overflowQ <= 1'b0;
    end else begin
      keyEvent <= pushReq;
      if (doPush) begin
        mem[wrPtr[PW-1:0]] <= cand;
        wrPtr              <= wrPtr + PTR_ONE;
      end
      if (doPop) rdPtr <= rdPtr + PTR_ONE;
      if (pushReq && !doPush) overflowQ <= 1'b1;
      else if (bus.clr_ovf)   overflowQ <= 1'b0;
    end
  end
endmodule
